// File: rtl/fifo_rd_arb_pkg.sv
// fifo_rd_arb_pkg: shared types and helpers for the FIFO read-port arbiter.
//
// Contents:
//   arb_state_e  - arbiter FSM state (StIdle, StXfer)
//   IdxWDefault  - requester index width for the default 4-requester build
//   idx_width()  - requester index width for a given requester count
//   burst_beats()- burst length field to beat count (0 encodes 2^burst_w beats)

package fifo_rd_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StXfer = 1'b1
    } arb_state_e;

    localparam int unsigned NReqDefault = 4;
    localparam int unsigned IdxWDefault = $clog2(NReqDefault);

    // Index width; never below one bit so single-bit vectors stay legal.
    function automatic int unsigned idx_width(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // A zero length field means the longest burst the field can describe.
    function automatic int unsigned burst_beats(input int unsigned len,
                                                input int unsigned burst_w);
        return (len == 0) ? (32'd1 << burst_w) : len;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: bundles the FIFO read side and the consumer-facing
// signals of the read-port arbiter.
//
// Signals:
//   req       - per-requester request level, held for the whole burst
//   req_len   - packed burst lengths, slice i belongs to req[i]
//   rempty    - FIFO empty flag
//   rdata     - FIFO head word, valid whenever rempty=0
//   rinc      - FIFO pop strobe (combinational)
//   gnt       - registered one-hot grant
//   out_data  - registered popped word
//   out_valid - registered one-hot beat strobe
//   done      - one-cycle pulse when a burst completes or aborts
//   tmo       - one-cycle pulse on timeout abort
//
// Modports:
//   master - the arbiter
//   slave  - the FIFO plus consumers (environment side)

interface fifo_rd_arbiter_if #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned BURST_W = 4
);

    logic [N_REQ-1:0]         req;
    logic [N_REQ*BURST_W-1:0] req_len;
    logic                     rempty;
    logic [DWIDTH-1:0]        rdata;
    logic                     rinc;
    logic [N_REQ-1:0]         gnt;
    logic [DWIDTH-1:0]        out_data;
    logic [N_REQ-1:0]         out_valid;
    logic [N_REQ-1:0]         done;
    logic                     tmo;

    modport master (
        input  req, req_len, rempty, rdata,
        output rinc, gnt, out_data, out_valid, done, tmo
    );

    modport slave (
        output req, req_len, rempty, rdata,
        input  rinc, gnt, out_data, out_valid, done, tmo
    );

endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//
// Ports:
//   req_i         - request vector
//   last_winner_i - index of the previous completed winner
//   winner_o      - first requester found scanning upward from last_winner_i+1,
//                   wrapping at N_REQ-1 (holds last_winner_i when no request)
//   any_req_o     - at least one request bit is set

module rr_pick
    import fifo_rd_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IdxW = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IdxW-1:0]  last_winner_i,
    output logic [IdxW-1:0]  winner_o,
    output logic             any_req_o
);

    assign any_req_o = |req_i;

    always_comb begin
        int unsigned       off;
        int unsigned       cand;
        logic [IdxW-1:0]   cand_idx;
        winner_o = last_winner_i;
        off      = 0;
        cand     = 0;
        cand_idx = '0;
        // Walk from the farthest candidate to the nearest so that the nearest
        // requester after last_winner overwrites any farther one.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            off  = N_REQ - k;
            cand = 32'(last_winner_i) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IdxW'(cand);
            if (req_i[cand_idx]) begin
                winner_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin arbiter sharing the read side of an async FIFO
// among N_REQ consumers in the read clock domain.
//
// One consumer is granted at a time for a burst of up to 2^BURST_W words. Words
// are popped only while the FIFO is non-empty and steered to the granted
// consumer. A burst ends when its last word is popped or when the owner drops
// its request; either way done[winner] pulses for one cycle and gnt clears.
//
// Ports:
//   clk - read-domain clock
//   rst - synchronous, active-high reset
//   bus - fifo_rd_arbiter_if.master (FIFO read side + consumer outputs)
//
// Build option:
//   FIFO_RD_ARB_TIMEOUT_EN - when defined, a burst that sees TIMEOUT consecutive
//   empty cycles aborts and pulses tmo together with done. When undefined the
//   burst waits for data indefinitely and tmo is tied low.

module fifo_rd_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned BURST_W = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    fifo_rd_arbiter_if.master  bus
);

    localparam int unsigned IdxW = idx_width(N_REQ);
    localparam int unsigned RemW = BURST_W + 1;

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   winner_q, winner_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [RemW-1:0]   rem_q, rem_d;

    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ov_q, ov_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [DWIDTH-1:0] od_q, od_d;
    logic              tmo_q, tmo_d;

    logic [IdxW-1:0]    pick;
    logic               any_req;
    logic [BURST_W-1:0] pick_len;
    logic               win_req;
    logic               rinc;
    logic               burst_end;
    logic               tmo_hit;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i         (bus.req),
        .last_winner_i (last_q),
        .winner_o      (pick),
        .any_req_o     (any_req)
    );

    // Length field of the round-robin candidate.
    always_comb begin
        pick_len = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IdxW'(i) == pick) begin
                pick_len = bus.req_len[i*BURST_W +: BURST_W];
            end
        end
    end

    assign win_req = bus.req[winner_q];

    // Pop strobe: only in a live burst with data present, so the FIFO never
    // underflows and an abort cycle (owner request low) never pops.
    assign rinc = (state_q == StXfer) && !bus.rempty && win_req;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts consecutive empty cycles of a live burst; any pop restarts it.
    always_comb begin
        cnt_d   = cnt_q;
        tmo_hit = 1'b0;
        if (state_q == StXfer) begin
            if (rinc) begin
                cnt_d = '0;
            end else if (win_req) begin
                if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic timeout_unused;

    assign tmo_hit        = 1'b0;
    assign timeout_unused = (TIMEOUT != 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            winner_q <= '0;
            last_q   <= IdxW'(N_REQ - 1);
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            rem_q    <= rem_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        rem_d     = rem_q;
        burst_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d  = StXfer;
                    winner_d = pick;
                    rem_d    = RemW'(burst_beats(32'(pick_len), BURST_W));
                end
            end
            StXfer: begin
                if (!win_req || tmo_hit) begin
                    // Abort: round-robin pointer only advances on completion.
                    state_d   = StIdle;
                    burst_end = 1'b1;
                end else if (rinc) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == RemW'(1)) begin
                        state_d   = StIdle;
                        last_d    = winner_q;
                        burst_end = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        gnt_d = '0;
        if (state_d == StXfer) begin
            gnt_d[winner_d] = 1'b1;
        end

        ov_d = '0;
        od_d = od_q;
        if (rinc) begin
            ov_d[winner_q] = 1'b1;
            od_d           = bus.rdata;
        end

        done_d = '0;
        if (burst_end) begin
            done_d[winner_q] = 1'b1;
        end

        tmo_d = burst_end && tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= '0;
            ov_q   <= '0;
            done_q <= '0;
            od_q   <= '0;
            tmo_q  <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            ov_q   <= ov_d;
            done_q <= done_d;
            od_q   <= od_d;
            tmo_q  <= tmo_d;
        end
    end

    assign bus.rinc      = rinc;
    assign bus.gnt       = gnt_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.done      = done_q;
    assign bus.tmo       = tmo_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: randomized + directed bench for fifo_rd_arbiter against
// a transaction-level reference model (owner index, beats left, FIFO queue).

module tb_fifo_rd_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DWIDTH  = 8;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int          N       = N_REQ;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_rd_arbiter_if #(
        .N_REQ   (N_REQ),
        .DWIDTH  (DWIDTH),
        .BURST_W (BURST_W)
    ) bus ();

    fifo_rd_arbiter #(
        .N_REQ   (N_REQ),
        .DWIDTH  (DWIDTH),
        .BURST_W (BURST_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Stimulus controls, applied just after each rising edge.
    logic [N_REQ-1:0]         req_v;
    logic [N_REQ*BURST_W-1:0] len_v;
    logic                     rst_v;
    int                       stall_pct;
    int                       force_empty;
    logic [DWIDTH-1:0]        fifo_q[$];

    // Reference model.
    int                m_owner;
    int                m_last;
    int                m_left;
    int                m_beats;
    int                m_run;
    logic [N_REQ-1:0]  e_gnt, e_ov, e_done;
    logic [DWIDTH-1:0] e_od;
    logic              e_tmo;

    // Observed-event statistics.
    int               ov_cnt[N_REQ];
    int               done_cnt[N_REQ];
    int               tmo_cnt;
    int               gnt_log[$];
    logic [N_REQ-1:0] prev_gnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_left  = 0;
        m_beats = 0;
        m_run   = 0;
        e_gnt   = '0;
        e_ov    = '0;
        e_done  = '0;
        e_od    = '0;
        e_tmo   = 1'b0;
    endtask

    function automatic int len_of(input int i);
        int l;
        l = int'(len_v[i*BURST_W +: BURST_W]);
        return (l == 0) ? (1 << BURST_W) : l;
    endfunction

    task automatic model_step(input logic pop, input logic [DWIDTH-1:0] word);
        bit found;
        int c;
        if (rst_v) begin
            model_reset();
            return;
        end
        e_done = '0;
        e_tmo  = 1'b0;
        e_ov   = '0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && req_v[c]) begin
                    m_owner = c;
                    found   = 1'b1;
                end
            end
            if (found) begin
                m_left  = len_of(m_owner);
                m_beats = 0;
                m_run   = 0;
            end
        end else if (!req_v[m_owner]) begin
            e_done[m_owner] = 1'b1;
            m_owner         = -1;
        end else if (pop) begin
            e_ov[m_owner] = 1'b1;
            e_od          = word;
            m_left--;
            m_beats++;
            m_run = 0;
            if (m_left == 0) begin
                e_done[m_owner] = 1'b1;
                m_last          = m_owner;
                m_owner         = -1;
            end
        end else begin
`ifdef FIFO_RD_ARB_TIMEOUT_EN
            m_run++;
            if (m_run == TIMEOUT) begin
                e_done[m_owner] = 1'b1;
                e_tmo           = 1'b1;
                m_owner         = -1;
            end
`endif
        end
        e_gnt = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
        end
    endtask

    task automatic cycle();
        logic stall;
        logic pop;
        @(posedge clk);
        #1;
        rst         = rst_v;
        bus.req     = req_v;
        bus.req_len = len_v;
        stall       = ($urandom_range(99) < stall_pct);
        if (force_empty > 0) begin
            stall = 1'b1;
            force_empty--;
        end
        bus.rempty = (fifo_q.size() == 0) || stall;
        bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : DWIDTH'($urandom);
        @(negedge clk);
        pop = 1'b0;
        if (m_owner >= 0) begin
            pop = !bus.rempty && req_v[m_owner];
        end
        check("rinc", 32'(bus.rinc), 32'(pop));
        check("gnt", 32'(bus.gnt), 32'(e_gnt));
        check("out_valid", 32'(bus.out_valid), 32'(e_ov));
        check("out_data", 32'(bus.out_data), 32'(e_od));
        check("done", 32'(bus.done), 32'(e_done));
        check("tmo", 32'(bus.tmo), 32'(e_tmo));
        if (bus.rempty) begin
            check("no_underflow", 32'(bus.rinc), 32'd0);
        end
        for (int i = 0; i < N; i++) begin
            if (bus.out_valid[i]) ov_cnt[i]++;
            if (bus.done[i]) done_cnt[i]++;
            if (bus.gnt[i] && prev_gnt == '0) gnt_log.push_back(i);
        end
        if (bus.tmo) tmo_cnt++;
        prev_gnt = bus.gnt;
        model_step(pop, bus.rdata);
        if (pop) begin
            void'(fifo_q.pop_front());
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DWIDTH'($urandom));
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            ov_cnt[i]   = 0;
            done_cnt[i] = 0;
        end
        tmo_cnt = 0;
        gnt_log.delete();
    endtask

    task automatic set_len(input int i, input int l);
        len_v[i*BURST_W +: BURST_W] = BURST_W'(l);
    endtask

    // Runs until the model leaves the burst owned by `who`, then drops all
    // requests so no new burst starts.
    task automatic finish_burst(input int who);
        for (int c = 0; c < 60 && m_owner == who; c++) begin
            cycle();
        end
        check("burst_ended", 32'(m_owner != who), 32'd1);
        req_v = '0;
        repeat (3) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DWIDTH-1:0] w2;
        bit                stalled;

        rst         = 1'b1;
        bus.req     = '0;
        bus.req_len = '0;
        bus.rempty  = 1'b1;
        bus.rdata   = '0;
        req_v       = '0;
        len_v       = '0;
        rst_v       = 1'b1;
        stall_pct   = 0;
        force_empty = 0;
        prev_gnt    = '0;
        model_reset();
        clear_stats();

        // Reset state.
        repeat (2) cycle();
        rst_v = 1'b0;
        repeat (2) cycle();

        // All requesting, length 2, FIFO full: grants rotate 0,1,2,3,0.
        fill(40);
        for (int i = 0; i < N; i++) set_len(i, 2);
        req_v = '1;
        clear_stats();
        repeat (22) cycle();
        check("t1_ngrants", 32'(gnt_log.size() >= 5), 32'd1);
        if (gnt_log.size() >= 5) begin
            check("t1_g0", 32'(gnt_log[0]), 32'd0);
            check("t1_g1", 32'(gnt_log[1]), 32'd1);
            check("t1_g2", 32'(gnt_log[2]), 32'd2);
            check("t1_g3", 32'(gnt_log[3]), 32'd3);
            check("t1_g4", 32'(gnt_log[4]), 32'd0);
        end
        req_v = '0;
        repeat (3) cycle();

        // req[2] alone, len 0 (16 beats), 20 words available.
        fifo_q.delete();
        fill(20);
        len_v = '0;
        req_v = 4'b0100;
        clear_stats();
        cycle();
        finish_burst(2);
        check("t2_beats", 32'(ov_cnt[2]), 32'd16);
        check("t2_done", 32'(done_cnt[2]), 32'd1);

        // req[1], len 3, five empty cycles between pops 1 and 2.
        fifo_q.delete();
        fill(10);
        w2 = fifo_q[2];
        set_len(1, 3);
        req_v   = 4'b0010;
        stalled = 1'b0;
        clear_stats();
        cycle();
        for (int c = 0; c < 40 && m_owner == 1; c++) begin
            if (m_beats == 1 && !stalled) begin
                force_empty = 5;
                stalled     = 1'b1;
            end
            cycle();
        end
        req_v = '0;
        repeat (3) cycle();
        check("t3_beats", 32'(ov_cnt[1]), 32'd3);
        check("t3_done", 32'(done_cnt[1]), 32'd1);
        check("t3_last_word", 32'(bus.out_data), 32'(w2));

        // req[0] (5 beats) drops after its 2nd beat; req[1] gets the port next.
        fifo_q.delete();
        fill(20);
        set_len(0, 5);
        set_len(1, 2);
        req_v = 4'b0011;
        clear_stats();
        for (int c = 0; c < 40 && !(m_owner == 0 && m_beats == 2); c++) begin
            cycle();
        end
        req_v[0] = 1'b0;
        cycle();
        for (int c = 0; c < 10 && m_owner != 1; c++) begin
            cycle();
        end
        finish_burst(1);
        check("t4_beats0", 32'(ov_cnt[0]), 32'd2);
        check("t4_done0", 32'(done_cnt[0]), 32'd1);
        check("t4_ngrants", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            check("t4_second", 32'(gnt_log[1]), 32'd1);
        end

        // FIFO runs dry after 1 of 4 beats.
        fifo_q.delete();
        fill(1);
        set_len(3, 4);
        req_v = 4'b1000;
        clear_stats();
        cycle();
        for (int c = 0; c < 40 && m_owner == 3; c++) begin
            cycle();
        end
`ifdef FIFO_RD_ARB_TIMEOUT_EN
        req_v = '0;
        repeat (3) cycle();
        check("t5_tmo", 32'(tmo_cnt), 32'd1);
        check("t5_done", 32'(done_cnt[3]), 32'd1);
`else
        check("t5_gnt_held", 32'(bus.gnt), 32'h8);
        check("t5_no_tmo", 32'(tmo_cnt), 32'd0);
        req_v = '0;
        repeat (3) cycle();
`endif

        // Randomized traffic: requests/lengths change, random empty stalls.
        stall_pct = 25;
        for (int c = 0; c < 3000; c++) begin
            if (fifo_q.size() < 8) fill($urandom_range(16, 1));
            if ($urandom_range(9) == 0) begin
                req_v = N_REQ'($urandom);
                len_v = (N_REQ*BURST_W)'($urandom);
            end
            cycle();
        end
        req_v     = '0;
        stall_pct = 0;
        repeat (3) cycle();

        // Reset mid-burst: no done pulse, priority restarts at req[0].
        fifo_q.delete();
        fill(30);
        set_len(1, 1);
        req_v = 4'b0010;
        cycle();
        finish_burst(1);
        set_len(2, 8);
        req_v = 4'b0100;
        repeat (4) cycle();
        rst_v = 1'b1;
        cycle();
        rst_v = 1'b0;
        req_v = '1;
        clear_stats();
        cycle();
        check("t7_no_done", 32'(bus.done), 32'd0);
        repeat (3) cycle();
        check("t7_ngrants", 32'(gnt_log.size() >= 1), 32'd1);
        if (gnt_log.size() >= 1) begin
            check("t7_first", 32'(gnt_log[0]), 32'd0);
        end
        req_v = '0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Round-robin read-port arbiter that shares the single read side of an asynchronous FIFO (rinc / rempty / read data) among N_REQ consumers in the read clock domain. Each consumer requests a burst of up to 2^BURST_W words. The arbiter grants one consumer at a time, pops words only while the FIFO is non-empty, and steers each popped word to the granted consumer. It sits between the FIFO read-pointer/empty logic and the downstream consumers.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DWIDTH, 8, FIFO data width
- BURST_W, 4, burst-length field width; len 0 encodes 2^BURST_W beats
- TIMEOUT, 16, consecutive empty cycles before burst abort (used only with macro)

- clk  in  1  read-domain clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request level, held for the whole burst
- req_len  in  N_REQ*BURST_W  packed burst lengths; slice i belongs to req[i]
- rempty  in  1  FIFO empty flag
- rdata  in  DWIDTH  FIFO head word, valid whenever rempty=0
- rinc  out  1  FIFO pop strobe
- gnt  out  N_REQ  registered one-hot grant
- out_data  out  DWIDTH  registered popped word
- out_valid  out  N_REQ  registered one-hot beat strobe
- done  out  N_REQ  one-cycle pulse when a burst completes or aborts
- tmo  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states:
  - IDLE: gnt=0. If any req bit is set, select a winner by round-robin starting at last_winner+1, wrapping at N_REQ-1. Latch the winner index and its length, with remaining = (len==0 ? 2^BURST_W : len), width BURST_W+1. Go to XFER.
  - XFER: rinc = !rempty && req[winner].
  - Each pop: decrement remaining.
  - Pop when remaining==1: go to IDLE, last_winner <= winner.
  - req[winner] low in XFER: abort. rinc=0 that cycle, go to IDLE.
  - No pop is issued after an abort.
- Any transition XFER->IDLE drives done[winner]=1 for exactly the next cycle. In that same cycle gnt returns to 0.
- Data path: out_data <= rdata and out_valid <= onehot(winner) on every cycle where rinc=1. Otherwise out_valid <= 0 and out_data holds its value.
- Empty stalls do not consume burst length.
- rinc is never asserted while rempty=1 (no underflow).
- Environment contract: rempty reflects the FIFO pointer state of the current cycle.
- Requests that arrive during XFER wait; they are not preempted.
- Reset values:
  - state IDLE; last_winner = N_REQ-1, so req[0] wins first.
  - gnt, out_valid, done, tmo, rinc = 0; out_data = 0.
- Reset mid-burst drops the burst immediately. No done pulse is issued.

## Timing
- req seen in IDLE at cycle 0: gnt valid in cycle 1. Earliest rinc in cycle 1; matching out_valid/out_data in cycle 2.
- Back-to-back pops at one per cycle while rempty=0.
- Last pop in cycle k: done and gnt=0 in cycle k+1; next gnt no earlier than cycle k+2, giving one dead cycle between bursts.
- rinc is combinational from registered state, req and rempty. All other outputs are registered.

## Configuration
- FIFO_RD_ARB_TIMEOUT_EN defined:
  - A counter of consecutive XFER cycles with rempty=1 runs during XFER.
  - It clears on any pop.
  - When it reaches TIMEOUT, the burst aborts, pulsing done[winner] and tmo together in the next cycle.
- Not defined:
  - The counter is not built and tmo is tied to 0.
  - XFER waits indefinitely for data.

## Structure
- Package fifo_rd_arb_pkg holds:
  - state enum (IDLE, XFER);
  - idx width localparam, $clog2(N_REQ);
  - len function mapping 0 -> 2^BURST_W.
- One sub-module, rr_pick: combinational round-robin selector with inputs req and last_winner, outputs winner index and any_req.

## Test plan
- After rst, req=4'b1111, all lengths 2, FIFO full: grants in order 0,1,2,3,0. Each gnt window has exactly 2 rinc, a done pulse, and one dead cycle between bursts.
- req[2] alone, len=0, FIFO holding 20 words: exactly 16 pops, out_valid=4'b0100 for 16 cycles, then done[2].
- req[1], len=3, with rempty=1 for 5 cycles between pops 1 and 2: 3 pops total, no rinc while empty, out_data matches FIFO order.
- req[0] drops after the 2nd of 5 beats: no further rinc, done[0] pulse on the next cycle, and req[1] granted afterwards.
- With FIFO_RD_ARB_TIMEOUT_EN and TIMEOUT=16, FIFO empty after 1 of 4 beats: tmo and done pulse together 16 cycles later. Without the macro, gnt stays held.
- rst asserted mid-burst: next cycle gnt=0, rinc=0, no done pulse; after release, req[0] has priority.
